// File: rtl/ysyx_axi_pkg.sv
// Shared AXI4 constants, FSM state encodings and burst legality helper for the SRAM responder.
package ysyx_axi_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_WAIT,
        W_RESP
    } wr_state_e;

    // Whole-burst errors: beats wider than the bus, WRAP, and the reserved encoding.
    function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
        return (size > 3'd3) || (burst == BURST_WRAP) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/ysyx_lfsr20.sv
// Free-running 20-bit Fibonacci LFSR (x^20 + x^19 + 1) used to jitter response latency.
module ysyx_lfsr20 (
    input  logic        clk,
    input  logic        rst,
    output logic [19:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 20'h1;
        end else begin
            q <= {q[18:0], q[19] ^ q[18]};
        end
    end

endmodule

// File: rtl/ysyx_axi4_sram_slave.sv
// AXI4 responder backed by a 64-bit SRAM; independent read/write FSMs, one transaction each,
// FIXED/INCR bursts, fixed plus optional pseudo-random response latency.
module ysyx_axi4_sram_slave
    import ysyx_axi_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] BASE     = 32'h8000_0000,
    parameter int unsigned       DEPTH    = 4096,
    parameter int unsigned       LATENCY  = 2,
    parameter int unsigned       RAND_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        arburst,
    input  logic [2:0]        arsize,
    input  logic [7:0]        arlen,
    input  logic [3:0]        arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [3:0]        rid,
    output logic [63:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [1:0]        awburst,
    input  logic [2:0]        awsize,
    input  logic [7:0]        awlen,
    input  logic [3:0]        awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned SPAN  = DEPTH * 8;
    localparam int unsigned CNT_W = $clog2(LATENCY + 17);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [19:0]       lfsr_q;
    logic              unused_lfsr_c;
    logic [CNT_W-1:0]  lat_load_c;

    rd_state_e         rd_state_q;
    logic              arready_q, rvalid_q, rlast_q, rd_bad_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q, rd_burst_q;
    logic [2:0]        rd_size_q;
    logic [LEN_W-1:0]  rd_len_q, rd_beat_q;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic              rd_err_c;
    logic [IDX_W-1:0]  rd_idx_c;

    wr_state_e         wr_state_q;
    logic              awready_q, wready_q, bvalid_q, wr_bad_q, wr_err_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q, wr_burst_q;
    logic [2:0]        wr_size_q;
    logic [LEN_W-1:0]  wr_len_q, wr_beat_q;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]  wr_cnt_q;
    logic              wr_fire_c, wr_beat_err_c, mem_we_c;
    logic [IDX_W-1:0]  wr_idx_c;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] lo;
        logic [ADDR_W:0] hi;
        lo = (ADDR_W+1)'(BASE);
        hi = lo + (ADDR_W+1)'(SPAN);
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

    ysyx_lfsr20 u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );

    assign unused_lfsr_c = ^lfsr_q[19:4];
    assign lat_load_c    = CNT_W'(LATENCY) + ((RAND_LAT != 0) ? CNT_W'(lfsr_q[3:0]) : CNT_W'(0));

    // Per-beat address/error decode; out-of-range beats never index the array.
    assign rd_addr_d = rd_addr_q + ((rd_burst_q == BURST_FIXED) ? '0 : (ADDR_W'(1) << rd_size_q));
    assign rd_err_c  = rd_bad_q || !in_range(rd_addr_q);
    assign rd_idx_c  = IDX_W'((rd_addr_q - BASE) >> 3);

    assign wr_addr_d     = wr_addr_q + ((wr_burst_q == BURST_FIXED) ? '0 : (ADDR_W'(1) << wr_size_q));
    assign wr_idx_c      = IDX_W'((wr_addr_q - BASE) >> 3);
    assign wr_fire_c     = (wr_state_q == W_DATA) && wready_q && wvalid;
    assign wr_beat_err_c = wr_bad_q || !in_range(wr_addr_q) || (wlast != (wr_beat_q == wr_len_q));
    assign mem_we_c      = wr_fire_c && !wr_beat_err_c && !rst;

    // SRAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_q[wr_idx_c][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rd_bad_q   <= 1'b0;
            rd_burst_q <= BURST_FIXED;
            rd_size_q  <= '0;
            rd_len_q   <= '0;
            rd_beat_q  <= '0;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (arvalid && arready_q) begin
                        arready_q  <= 1'b0;
                        rid_q      <= arid;
                        rd_addr_q  <= araddr;
                        rd_len_q   <= arlen;
                        rd_size_q  <= arsize;
                        rd_burst_q <= arburst;
                        rd_bad_q   <= burst_bad(arburst, arsize);
                        rd_beat_q  <= '0;
                        rd_cnt_q   <= lat_load_c;
                        rd_state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (rd_cnt_q == '0) begin
                        rdata_q    <= rd_err_c ? '0 : mem_q[rd_idx_c];
                        rresp_q    <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
                        rlast_q    <= (rd_beat_q == rd_len_q);
                        rvalid_q   <= 1'b1;
                        rd_state_q <= R_DATA;
                    end else begin
                        rd_cnt_q <= rd_cnt_q - CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            arready_q  <= 1'b1;
                            rd_state_q <= R_IDLE;
                        end else begin
                            // Zero count: next word is fetched after exactly one idle cycle.
                            rd_beat_q  <= rd_beat_q + LEN_W'(1);
                            rd_addr_q  <= rd_addr_d;
                            rd_cnt_q   <= '0;
                            rd_state_q <= R_WAIT;
                        end
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bid_q      <= '0;
            bresp_q    <= RESP_OKAY;
            wr_bad_q   <= 1'b0;
            wr_err_q   <= 1'b0;
            wr_burst_q <= BURST_FIXED;
            wr_size_q  <= '0;
            wr_len_q   <= '0;
            wr_beat_q  <= '0;
            wr_addr_q  <= '0;
            wr_cnt_q   <= '0;
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (awvalid && awready_q) begin
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        bid_q      <= awid;
                        wr_addr_q  <= awaddr;
                        wr_len_q   <= awlen;
                        wr_size_q  <= awsize;
                        wr_burst_q <= awburst;
                        wr_bad_q   <= burst_bad(awburst, awsize);
                        wr_err_q   <= burst_bad(awburst, awsize);
                        wr_beat_q  <= '0;
                        wr_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wr_fire_c) begin
                        if (wr_beat_err_c) begin
                            wr_err_q <= 1'b1;
                        end
                        if (wr_beat_q == wr_len_q) begin
                            wready_q   <= 1'b0;
                            wr_cnt_q   <= lat_load_c;
                            wr_state_q <= W_WAIT;
                        end else begin
                            wr_beat_q <= wr_beat_q + LEN_W'(1);
                            wr_addr_q <= wr_addr_d;
                        end
                    end
                end
                W_WAIT: begin
                    if (wr_cnt_q == '0) begin
                        bvalid_q   <= 1'b1;
                        bresp_q    <= wr_err_q ? RESP_SLVERR : RESP_OKAY;
                        wr_state_q <= W_RESP;
                    end else begin
                        wr_cnt_q <= wr_cnt_q - CNT_W'(1);
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wr_state_q <= W_IDLE;
                    end
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    assign arready = arready_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rvalid  = rvalid_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign bvalid  = bvalid_q;

endmodule
